// File: rtl/gp_timer_if.sv
// gp_timer control interface: count enable in, sticky expiry flag out.
// Clock and reset stay as plain module ports.
interface gp_timer_if;
    logic i_start;
    logic o_timeout;

    modport master (
        output i_start,
        input  o_timeout
    );

    modport slave (
        input  i_start,
        output o_timeout
    );
endinterface

// File: rtl/gp_timer.sv
// gp_timer: one-shot timeout timer counting enabled cycles.
// Sticky expiry flag, cleared only by the async active-low reset.
module gp_timer #(
    parameter int unsigned TIMEOUT = 1500000,
    parameter int          RST_LVL = 0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    gp_timer_if.slave  bus
);

    localparam int CNT_W = $clog2(64'(TIMEOUT) + 64'd1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    // Only an active-low reset is implemented.
    if (RST_LVL != 0) begin : g_bad_rst_lvl
        $error("gp_timer: RST_LVL must be 0");
    end

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             to_nxt;

    // Next-state: hold once expired, count while enabled, else hold.
    always_comb begin
        cnt_nxt = cnt;
        to_nxt  = bus.o_timeout;
        unique case (1'b1)
            bus.o_timeout: begin
                cnt_nxt = cnt;
                to_nxt  = 1'b1;
            end
            (!bus.o_timeout && bus.i_start): begin
                cnt_nxt = cnt + 1'b1;
                to_nxt  = (cnt == CNT_LAST);
            end
            (!bus.o_timeout && !bus.i_start): begin
                cnt_nxt = cnt;
                to_nxt  = 1'b0;
            end
            default: begin
                cnt_nxt = cnt;
                to_nxt  = bus.o_timeout;
            end
        endcase
    end

    // Counter and flag registers with asynchronous clear.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt           <= '0;
            bus.o_timeout <= 1'b0;
        end else begin
            cnt           <= cnt_nxt;
            bus.o_timeout <= to_nxt;
        end
    end

    a_sticky : assert property (
        @(posedge i_clk) disable iff (!i_rst)
        bus.o_timeout |=> bus.o_timeout
    );

    a_range : assert property (
        @(posedge i_clk) disable iff (!i_rst)
        cnt <= CNT_MAX
    );

    a_flag : assert property (
        @(posedge i_clk) disable iff (!i_rst)
        bus.o_timeout == (cnt == CNT_MAX)
    );

endmodule

// File: tb/tb_gp_timer.sv
// tb_gp_timer: checks TIMEOUT=5 and TIMEOUT=1 timers side by side.
// Shared stimulus, per-instance expectations from a scoreboard queue.
module tb_gp_timer;

    logic clk;
    logic rst;
    logic start;

    gp_timer_if t5_if ();
    gp_timer_if t1_if ();

    assign t5_if.i_start = start;
    assign t1_if.i_start = start;

    gp_timer #(.TIMEOUT(5), .RST_LVL(0)) u_t5 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (t5_if.slave)
    );

    gp_timer #(.TIMEOUT(1), .RST_LVL(0)) u_t1 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (t1_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    a_start_known : assert property (
        @(posedge clk) disable iff (!rst)
        !$isunknown(start)
    );

    typedef struct {
        logic rst;
        logic start;
        logic e5;
        logic e1;
    } vec_t;

    typedef struct {
        logic  e5;
        logic  e1;
        string tag;
    } exp_t;

    vec_t vecs[$];
    exp_t expq[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input logic act, input logic req,
                       input string tag);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: o_timeout=%b expected %b",
                     tag, act, req);
        end
    endtask

    task automatic add(input int n, input logic r,
                       input logic s, input logic e5,
                       input logic e1);
        vec_t v;
        v.rst   = r;
        v.start = s;
        v.e5    = e5;
        v.e1    = e1;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic step(input logic r, input logic s,
                        input logic e5, input logic e1,
                        input string tag);
        exp_t e;
        exp_t got;
        rst   = r;
        start = s;
        e.e5  = e5;
        e.e1  = e1;
        e.tag = tag;
        expq.push_back(e);
        @(posedge clk);
        #1;
        if (expq.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            got = expq.pop_front();
            chk(t5_if.o_timeout, got.e5, {got.tag, "/t5"});
            chk(t1_if.o_timeout, got.e1, {got.tag, "/t1"});
        end
    endtask

    task automatic async_rst(input string tag);
        #3;
        rst = 1'b0;
        #1;
        chk(t5_if.o_timeout, 1'b0, {tag, "/async/t5"});
        chk(t1_if.o_timeout, 1'b0, {tag, "/async/t1"});
        @(posedge clk);
        #1;
        chk(t5_if.o_timeout, 1'b0, {tag, "/held/t5"});
        chk(t1_if.o_timeout, 1'b0, {tag, "/held/t1"});
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;

        // reset state
        add(2, 0, 0, 0, 0);
        // continuous counting, then sticky
        add(4, 1, 1, 0, 1);
        add(1, 1, 1, 1, 1);
        add(20, 1, 1, 1, 1);
        // reset wins over start
        add(1, 0, 1, 0, 0);
        // pause keeps progress
        add(3, 1, 1, 0, 1);
        add(10, 1, 0, 0, 1);
        add(1, 1, 1, 0, 1);
        add(1, 1, 1, 1, 1);
        add(1, 0, 0, 0, 0);
        // idle never expires
        add(10, 1, 0, 0, 0);
        add(1, 1, 1, 0, 1);
        add(3, 1, 0, 0, 1);
        add(1, 0, 0, 0, 0);
        // detect-style N=4
        add(4, 1, 1, 0, 1);
        add(1, 0, 0, 0, 0);
        // detect-style N=5
        add(4, 1, 1, 0, 1);
        add(1, 1, 1, 1, 1);
        add(1, 0, 0, 0, 0);
        // detect-style N=6
        add(4, 1, 1, 0, 1);
        add(2, 1, 1, 1, 1);
        add(1, 0, 0, 0, 0);

        #2;
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].start,
                 vecs[i].e5, vecs[i].e1,
                 $sformatf("vec%0d", i));
        end

        // expire, async clear, re-run
        for (int i = 0; i < 4; i++) step(1, 1, 0, 1, "exp_a");
        step(1, 1, 1, 1, "exp_a_hit");
        async_rst("clr_expired");
        for (int i = 0; i < 4; i++) step(1, 1, 0, 1, "rerun");
        step(1, 1, 1, 1, "rerun_hit");

        // reset one short of expiry
        step(0, 0, 0, 0, "pre_rst");
        for (int i = 0; i < 4; i++) step(1, 1, 0, 1, "short");
        async_rst("clr_short");
        for (int i = 0; i < 4; i++) step(1, 1, 0, 1, "full");
        step(1, 1, 1, 1, "full_hit");

        if (expq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d left over",
                     expq.size());
        end

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

endmodule
